// File: rtl/cpu_pkg.sv
// Shared program-memory geometry and loader state encoding.
// The CHECK state exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package cpu_pkg;

  localparam int unsigned PM_ADDR_W = 5;
  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned PM_DEPTH  = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CNT_W     = PM_ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    ST_CHECK = 3'd7
`endif
  } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: count byte N, then N 16-bit words (high byte
// first) written to program memory while the CPU is held.
// Optional: PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module program_loader
  import cpu_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_in_valid,
  input  logic [BYTE_W-1:0]    i_in_data,
  output logic                 o_in_ready,
  output logic                 o_pm_we,
  output logic [PM_ADDR_W-1:0] o_pm_addr,
  output logic [INSTR_W-1:0]   o_pm_wdata,
  output logic                 o_cpu_hold,
  output logic                 o_load_done,
  output logic                 o_load_error
);

  loader_state_e         r_state,    w_state_nxt;
  logic [CNT_W-1:0]      r_n,        w_n_nxt;
  logic [BYTE_W-1:0]     r_hi,       w_hi_nxt;
  logic [PM_ADDR_W-1:0]  r_idx,      w_idx_nxt;
  logic                  r_in_ready, w_in_ready_nxt;
  logic                  r_pm_we,    w_pm_we_nxt;
  logic [PM_ADDR_W-1:0]  r_pm_addr,  w_pm_addr_nxt;
  logic [INSTR_W-1:0]    r_pm_wdata, w_pm_wdata_nxt;
  logic                  r_cpu_hold, w_cpu_hold_nxt;
  logic                  r_done,     w_done_nxt;
  logic                  r_err,      w_err_nxt;
  logic                  w_xfer;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]     r_csum,     w_csum_nxt;
`endif

  // Next-state, datapath and next-output logic; outputs are registered from the next state.
  always_comb begin
    w_state_nxt    = r_state;
    w_n_nxt        = r_n;
    w_hi_nxt       = r_hi;
    w_idx_nxt      = r_idx;
    w_pm_addr_nxt  = r_pm_addr;
    w_pm_wdata_nxt = r_pm_wdata;
    w_in_ready_nxt = 1'b0;
    w_pm_we_nxt    = 1'b0;
    w_cpu_hold_nxt = 1'b1;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_xfer         = i_in_valid & r_in_ready;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    w_csum_nxt     = r_csum;
`endif

    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          w_state_nxt = ST_COUNT;
          w_idx_nxt   = '0;
        end
      end
      ST_COUNT: begin
        if (w_xfer) begin
          w_n_nxt = i_in_data[CNT_W-1:0];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          w_csum_nxt = i_in_data;
`endif
          if ((i_in_data == 8'd0) || (i_in_data > 8'(PM_DEPTH))) w_state_nxt = ST_ERROR;
          else                                                    w_state_nxt = ST_HI;
        end
      end
      ST_HI: begin
        if (w_xfer) begin
          w_hi_nxt    = i_in_data;
          w_state_nxt = ST_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          w_csum_nxt  = r_csum ^ i_in_data;
`endif
        end
      end
      ST_LO: begin
        if (w_xfer) begin
          w_pm_addr_nxt  = r_idx;
          w_pm_wdata_nxt = {r_hi, i_in_data};
          w_state_nxt    = ST_WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          w_csum_nxt     = r_csum ^ i_in_data;
`endif
        end
      end
      ST_WRITE: begin
        w_idx_nxt = r_idx + PM_ADDR_W'(1);
        if ({1'b0, r_idx} == (r_n - CNT_W'(1))) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          w_state_nxt = ST_CHECK;
`else
          w_state_nxt = ST_DONE;
`endif
        end else begin
          w_state_nxt = ST_HI;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (w_xfer) begin
          if (i_in_data == r_csum) w_state_nxt = ST_DONE;
          else                     w_state_nxt = ST_ERROR;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_IDLE:                    w_cpu_hold_nxt = 1'b0;
      ST_COUNT, ST_HI, ST_LO:     w_in_ready_nxt = 1'b1;
      ST_WRITE:                   w_pm_we_nxt    = 1'b1;
      ST_DONE: begin
        w_done_nxt     = 1'b1;
        w_cpu_hold_nxt = 1'b0;
      end
      ST_ERROR:                   w_err_nxt      = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK:                   w_in_ready_nxt = 1'b1;
`endif
      default:                    w_cpu_hold_nxt = 1'b1;
    endcase
  end

  // State, datapath and output registers; reset forces everything idle and zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_n        <= '0;
      r_hi       <= '0;
      r_idx      <= '0;
      r_in_ready <= 1'b0;
      r_pm_we    <= 1'b0;
      r_pm_addr  <= '0;
      r_pm_wdata <= '0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_n        <= w_n_nxt;
      r_hi       <= w_hi_nxt;
      r_idx      <= w_idx_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_pm_we    <= w_pm_we_nxt;
      r_pm_addr  <= w_pm_addr_nxt;
      r_pm_wdata <= w_pm_wdata_nxt;
      r_cpu_hold <= w_cpu_hold_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_csum     <= w_csum_nxt;
`endif
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_pm_we      = r_pm_we;
  assign o_pm_addr    = r_pm_addr;
  assign o_pm_wdata   = r_pm_wdata;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_load_done  = r_done;
  assign o_load_error = r_err;

endmodule

// File: tb/tb_program_loader.sv
// Directed + randomized bench for program_loader with a stream-level reference model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        o_in_ready, o_pm_we, o_cpu_hold, o_load_done, o_load_error;
  logic [4:0]  o_pm_addr;
  logic [15:0] o_pm_wdata;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0]  stream[$];
  logic [20:0] exp_w[$];
  logic [20:0] got_w[$];
  bit          exp_ok;

  always #5 clk = ~clk;

  program_loader dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (o_in_ready),
    .o_pm_we      (o_pm_we),
    .o_pm_addr    (o_pm_addr),
    .o_pm_wdata   (o_pm_wdata),
    .o_cpu_hold   (o_cpu_hold),
    .o_load_done  (o_load_done),
    .o_load_error (o_load_error)
  );

  // Capture every program-memory write seen by the memory.
  always @(negedge clk) if (o_pm_we === 1'b1) got_w.push_back({o_pm_addr, o_pm_wdata});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected writes and final outcome from the raw byte stream.
  task automatic model();
    int n;
    logic [7:0] x;
    exp_w.delete();
    exp_ok = 1'b0;
    n = int'(stream[0]);
    if (n < 1 || n > 32) return;
    for (int i = 0; i < n; i++) exp_w.push_back({5'(i), stream[1 + 2*i], stream[2 + 2*i]});
    exp_ok = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 0; i < 1 + 2*n; i++) x ^= stream[i];
    exp_ok = (stream[1 + 2*n] == x);
`endif
  endtask

  task automatic add_csum(input bit good);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (stream[i]) x ^= stream[i];
    if (!good) x ^= 8'($urandom_range(255, 1));
    stream.push_back(x);
`else
    if (good) return;
`endif
  endtask

  task automatic build_random(input int n);
    stream.delete();
    stream.push_back(8'(n));
    for (int i = 0; i < 2*n; i++) stream.push_back(8'($urandom));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_hold", o_cpu_hold, 1);
    check("start_done_clr", o_load_done, 0);
    check("start_err_clr", o_load_error, 0);
    check("start_ready", o_in_ready, 1);
  endtask

  // Feed stream bytes; mode 0 always valid, 1 toggling, 2 random. Stops early after stop_w writes.
  task automatic feed(input int mode, input bit busy_starts, input int stop_w, output int idx);
    int cyc;
    bit v, rdy;
    idx = 0;
    cyc = 0;
    while (idx < stream.size() && cyc < 4000) begin
      if (o_load_done === 1'b1 || o_load_error === 1'b1) break;
      if (stop_w != 0 && got_w.size() >= stop_w) break;
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = ($urandom_range(99) < 60);
      endcase
      in_valid = v;
      in_data  = v ? stream[idx] : 8'($urandom);
      start    = busy_starts && ($urandom_range(9) == 0);
      rdy      = o_in_ready;
      @(posedge clk); #1;
      if (v && rdy) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic session(input string tag, input int mode, input bit busy_starts);
    int idx, cyc;
    model();
    got_w.delete();
    do_start();
    feed(mode, busy_starts, 0, idx);
    check({tag, "_consumed"}, idx, stream.size());
    cyc = 0;
    while (!(o_load_done === 1'b1 || o_load_error === 1'b1) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_ended"}, o_load_done | o_load_error, 1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_nwrites"}, got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_w[i], exp_w[i]);
    check({tag, "_done"}, o_load_done, exp_ok);
    check({tag, "_error"}, o_load_error, !exp_ok);
    check({tag, "_hold"}, o_cpu_hold, !exp_ok);
    check({tag, "_ready"}, o_in_ready, 0);
    check({tag, "_we"}, o_pm_we, 0);
    if (exp_w.size() > 0)
      check({tag, "_hold_bus"}, {o_pm_addr, o_pm_wdata}, exp_w[exp_w.size() - 1]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, o_in_ready, 0);
    check({tag, "_we"}, o_pm_we, 0);
    check({tag, "_addr"}, o_pm_addr, 0);
    check({tag, "_wdata"}, o_pm_wdata, 0);
    check({tag, "_hold"}, o_cpu_hold, 0);
    check({tag, "_done"}, o_load_done, 0);
    check({tag, "_error"}, o_load_error, 0);
  endtask

  initial begin
    int idx, nb;

    // Reset state and idle behaviour after release.
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_ready", o_in_ready, 0);
    check("idle_hold", o_cpu_hold, 0);

    // Two-word directed load.
    stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    add_csum(1'b1);
    session("two_words", 0, 1'b0);

    // Out-of-range count bytes.
    stream = '{8'h00};
    session("count00", 0, 1'b0);
    stream = '{8'h21};
    session("count21", 2, 1'b0);

    // Full-depth load with in_valid toggling.
    build_random(32);
    add_csum(1'b1);
    session("n32_toggle", 1, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    stream = '{8'h01, 8'h12, 8'h34, 8'h27};
    session("csum_good", 0, 1'b1);
    stream = '{8'h01, 8'h12, 8'h34, 8'h00};
    session("csum_bad", 0, 1'b1);
`endif

    // Randomized sessions with stalls and ignored busy starts.
    for (int s = 0; s < 8; s++) begin
      if ($urandom_range(5) == 0) begin
        stream.delete();
        stream.push_back(($urandom_range(1) == 0) ? 8'h00 : 8'($urandom_range(255, 33)));
      end else begin
        build_random(int'($urandom_range(32, 1)));
        add_csum($urandom_range(3) != 0);
      end
      session($sformatf("rnd%0d", s), 2, 1'b1);
    end

    // Reset mid-session after the addr2 write of an N=5 load.
    build_random(5);
    add_csum(1'b1);
    model();
    got_w.delete();
    do_start();
    feed(0, 1'b0, 3, idx);
    check("mid_writes_before", got_w.size(), 3);
    for (int i = 0; i < 3 && i < got_w.size(); i++)
      check($sformatf("mid_w%0d", i), got_w[i], exp_w[i]);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    nb = got_w.size();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mid_no_more_we", got_w.size(), nb);
    check("mid_idle_ready", o_in_ready, 0);
    check("mid_idle_hold", o_cpu_hold, 0);

    // Clean restart after the aborted session.
    build_random(5);
    add_csum(1'b1);
    session("restart", 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 clock  input  1  single clock; all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  one-cycle pulse; begins a load session.
REQ-004 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-005 in_data  input  8  stream byte.
REQ-006 in_ready  output  1  loader accepts in_data this cycle; transfer = in_valid & in_ready.
REQ-007 pm_we  output  1  program-memory write strobe, one cycle per word.
REQ-008 pm_addr  output  5  program-memory word address (same width as PC).
REQ-009 pm_wdata  output  16  instruction word written.
REQ-010 cpu_hold  output  1  holds control unit PC at 0 / stalled while loading.
REQ-011 load_done  output  1  level; last session completed successfully.
REQ-012 load_error  output  1  level; last session aborted.

Function
REQ-013 Stream format SHALL be: count byte N, then N words sent high byte first; N valid range 1..32.
REQ-014 States SHALL be IDLE, COUNT, HI, LO, WRITE, DONE, ERROR (plus CHECK when REQ-032 is enabled).
REQ-015 start in IDLE, DONE or ERROR SHALL move to COUNT next cycle, set cpu_hold=1, and clear load_done, load_error, word index.
REQ-016 start in any other state SHALL be ignored.
REQ-017 in_ready SHALL be 1 only in COUNT, HI, LO and CHECK; 0 elsewhere.
REQ-018 COUNT: on transfer, N=in_data[5:0]; if in_data==0 or in_data>32 -> ERROR, else -> HI.
REQ-019 HI: on transfer, latch high byte -> LO; LO: on transfer, latch low byte -> WRITE.
REQ-020 WRITE: pm_we=1 for exactly one cycle with pm_wdata={high,low}, pm_addr=word index; in_ready=0.
REQ-021 After WRITE, index increments; if the word written was index N-1 -> DONE (or CHECK), else -> HI.
REQ-022 Write latency SHALL be one cycle: pm_we asserts in the cycle after the low-byte transfer.
REQ-023 pm_addr SHALL never wrap: N=32 writes addresses 0..31 exactly once; no write beyond N-1.
REQ-024 Stalls (in_valid=0) in COUNT/HI/LO SHALL hold state and registers indefinitely.
REQ-025 DONE: load_done=1, cpu_hold=0, held until next start.
REQ-026 ERROR: load_error=1, cpu_hold=1, pm_we=0, held until next start; words already written are not rolled back.
REQ-027 pm_addr and pm_wdata SHALL hold last values when pm_we=0.

Reset
REQ-028 reset low SHALL immediately force IDLE, in_ready=0, pm_we=0, pm_addr=0, pm_wdata=0, cpu_hold=0, load_done=0, load_error=0.
REQ-029 reset asserted mid-session SHALL abort with no further pm_we; any partial byte is discarded.
REQ-030 After reset release, the loader SHALL remain in IDLE until start.

Configuration
REQ-031 Macro PROGRAM_LOADER_CHECKSUM_EN selects checksum checking.
REQ-032 Defined: after word N-1 go to CHECK; accept one byte; if it equals XOR of the count byte and all data bytes -> DONE, else -> ERROR.
REQ-033 Not defined: CHECK state and accumulator absent; after word N-1 go straight to DONE.

Structure
REQ-034 cpu_pkg SHALL hold PM_ADDR_W=5, INSTR_W=16, PM_DEPTH=32 and the loader state enum typedef.
REQ-035 No sub-module; byte assembly and checksum accumulation stay inline.

Verification
REQ-036 start, bytes 02,12,34,AB,CD -> pm_we at addr0 data 1234, then addr1 data ABCD; load_done=1, cpu_hold=0.
REQ-037 count byte 00 (and separately 21h) -> ERROR, load_error=1, cpu_hold=1, no pm_we.
REQ-038 N=32 with in_valid toggling every other cycle -> 32 writes, addresses 0..31 in order, none after 31.
REQ-039 reset pulled low after addr2 write of N=5 -> all outputs at reset values same cycle; no further pm_we; restart loads cleanly.
REQ-040 With PROGRAM_LOADER_CHECKSUM_EN: 01,12,34, checksum 27 -> DONE; checksum 00 -> ERROR; start pulses while busy ignored.
